// File: rtl/emif_pkg.sv
// Shared widths and FSM state types for the EMIF burst responder.
package emif_pkg;

  localparam int EMIF_ADDR_W   = 28;
  localparam int EMIF_DATA_W   = 256;
  localparam int EMIF_BURST_W  = 6;
  localparam int EMIF_WORD_OFS = 5;
  localparam int EMIF_MAXBURST = 32;

  typedef enum logic [1:0] {
    RD_IDLE   = 2'd0,
    RD_WAIT   = 2'd1,
    RD_STREAM = 2'd2
  } rd_state_e;

  typedef enum logic {
    WR_IDLE  = 1'b0,
    WR_BURST = 1'b1
  } wr_state_e;

endpackage

// File: rtl/emif_burst_responder_if.sv
// Avalon-MM write and read master bundle, named one-to-one with the master ports.
interface emif_burst_responder_if;
  import emif_pkg::*;

  logic [EMIF_ADDR_W-1:0]  emif_wr_addr;
  logic                    emif_wr_write;
  logic [EMIF_DATA_W-1:0]  emif_wr_wdata;
  logic [EMIF_BURST_W-1:0] emif_wr_burstcount;
  logic                    emif_wr_waitrequest;

  logic [EMIF_ADDR_W-1:0]  emif_rd_addr;
  logic                    emif_rd_read;
  logic [EMIF_BURST_W-1:0] emif_rd_burstcount;
  logic                    emif_rd_waitrequest;
  logic [EMIF_DATA_W-1:0]  emif_rd_rdata;
  logic                    emif_rd_readdatavalid;

  modport master (
    output emif_wr_addr, emif_wr_write, emif_wr_wdata, emif_wr_burstcount,
    input  emif_wr_waitrequest,
    output emif_rd_addr, emif_rd_read, emif_rd_burstcount,
    input  emif_rd_waitrequest, emif_rd_rdata, emif_rd_readdatavalid
  );

  modport slave (
    input  emif_wr_addr, emif_wr_write, emif_wr_wdata, emif_wr_burstcount,
    output emif_wr_waitrequest,
    input  emif_rd_addr, emif_rd_read, emif_rd_burstcount,
    output emif_rd_waitrequest, emif_rd_rdata, emif_rd_readdatavalid
  );

endinterface

// File: rtl/emif_sdp_ram.sv
// Simple dual-port RAM with a registered read port; a same-cycle write to the
// word being read returns the previous contents.
module emif_sdp_ram #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/emif_burst_responder.sv
// Avalon-MM burst responder: write bursts land in on-chip RAM, read bursts are
// returned after a fixed latency with optional write stalls and read gaps.
module emif_burst_responder
  import emif_pkg::*;
#(
  parameter int ADDR_W         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int WR_STALL_EVERY = 0,
  parameter int RD_GAP_EVERY   = 0
) (
  input  logic                   emif_br_clk,
  input  logic                   emif_br_reset,
  emif_burst_responder_if.slave  bus,
  output logic                   err_zero_burst
);

  localparam int LO = EMIF_WORD_OFS;
  localparam int HI = ADDR_W + EMIF_WORD_OFS - 1;
  localparam logic [15:0] STALL_LAST = 16'(WR_STALL_EVERY > 0 ? WR_STALL_EVERY - 1 : 0);
  localparam logic [15:0] GAP_LAST   = 16'(RD_GAP_EVERY > 0 ? RD_GAP_EVERY - 1 : 0);
  localparam logic [3:0]  WAIT_INIT  = 4'(RD_LATENCY - 2);

  wr_state_e               wr_state;
  logic [EMIF_BURST_W-1:0] wr_remaining;
  logic [ADDR_W-1:0]       wr_idx_next;
  logic [ADDR_W-1:0]       wr_ram_addr;
  logic [15:0]             wr_beat_cnt;
  logic                    wr_stall;
  logic                    wr_accept;
  logic                    wr_zero;
  logic                    ram_we;

  rd_state_e               rd_state;
  logic [ADDR_W-1:0]       rd_idx;
  logic [EMIF_BURST_W-1:0] rd_left;
  logic [3:0]              rd_wait_cnt;
  logic [15:0]             gap_cnt;
  logic                    gap_pend;
  logic                    rd_accept;
  logic                    rd_zero;
  logic                    rd_issue;
  logic                    rd_valid_q;
  logic                    err_q;
  logic [EMIF_DATA_W-1:0]  ram_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.emif_wr_addr[EMIF_ADDR_W-1:HI+1], bus.emif_wr_addr[LO-1:0],
                              bus.emif_rd_addr[EMIF_ADDR_W-1:HI+1], bus.emif_rd_addr[LO-1:0]};

  assign bus.emif_wr_waitrequest = emif_br_reset | wr_stall;
  assign wr_accept   = bus.emif_wr_write & ~bus.emif_wr_waitrequest;
  assign wr_zero     = (wr_state == WR_IDLE) && (bus.emif_wr_burstcount == '0);
  assign ram_we      = wr_accept & ~wr_zero;
  assign wr_ram_addr = (wr_state == WR_IDLE) ? bus.emif_wr_addr[HI:LO] : wr_idx_next;

  always_ff @(posedge emif_br_clk) begin
    if (emif_br_reset) begin
      wr_state     <= WR_IDLE;
      wr_remaining <= '0;
      wr_idx_next  <= '0;
    end else if (wr_accept) begin
      case (wr_state)
        WR_IDLE: begin
          if (bus.emif_wr_burstcount > 6'd1) begin
            wr_state     <= WR_BURST;
            wr_remaining <= bus.emif_wr_burstcount - 6'd1;
            wr_idx_next  <= bus.emif_wr_addr[HI:LO] + 1'b1;
          end
        end
        WR_BURST: begin
          wr_remaining <= wr_remaining - 6'd1;
          wr_idx_next  <= wr_idx_next + 1'b1;
          if (wr_remaining == 6'd1) wr_state <= WR_IDLE;
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  // Accepted beats are counted across bursts; the Nth one buys a single stall cycle.
  always_ff @(posedge emif_br_clk) begin
    if (emif_br_reset) begin
      wr_beat_cnt <= '0;
      wr_stall    <= 1'b0;
    end else begin
      wr_stall <= 1'b0;
      if (WR_STALL_EVERY > 0 && wr_accept) begin
        if (wr_beat_cnt == STALL_LAST) begin
          wr_beat_cnt <= '0;
          wr_stall    <= 1'b1;
        end else begin
          wr_beat_cnt <= wr_beat_cnt + 16'd1;
        end
      end
    end
  end

  assign bus.emif_rd_waitrequest = emif_br_reset | (rd_state != RD_IDLE);
  assign rd_accept = bus.emif_rd_read & ~bus.emif_rd_waitrequest;
  assign rd_zero   = bus.emif_rd_burstcount == '0;

  // A RAM read is issued one cycle before its beat is presented.
  always_comb begin
    rd_issue = 1'b0;
    if (!emif_br_reset) begin
      case (rd_state)
        RD_WAIT:   rd_issue = (rd_wait_cnt == 4'd0);
        RD_STREAM: rd_issue = (rd_left != '0) && !gap_pend;
        default:   rd_issue = 1'b0;
      endcase
    end
  end

  always_ff @(posedge emif_br_clk) begin
    if (emif_br_reset) begin
      rd_state    <= RD_IDLE;
      rd_idx      <= '0;
      rd_left     <= '0;
      rd_wait_cnt <= '0;
      gap_cnt     <= '0;
      gap_pend    <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_accept && !rd_zero) begin
            rd_state    <= RD_WAIT;
            rd_idx      <= bus.emif_rd_addr[HI:LO];
            rd_left     <= bus.emif_rd_burstcount;
            rd_wait_cnt <= WAIT_INIT;
            gap_cnt     <= '0;
            gap_pend    <= 1'b0;
          end
        end
        RD_WAIT: begin
          if (rd_wait_cnt != 4'd0) rd_wait_cnt <= rd_wait_cnt - 4'd1;
          else                     rd_state    <= RD_STREAM;
        end
        RD_STREAM: begin
          if (rd_left == '0) rd_state <= RD_IDLE;
          else if (gap_pend) gap_pend <= 1'b0;
        end
        default: rd_state <= RD_IDLE;
      endcase
      if (rd_issue) begin
        rd_left <= rd_left - 6'd1;
        rd_idx  <= rd_idx + 1'b1;
        if (RD_GAP_EVERY > 0) begin
          if (gap_cnt == GAP_LAST) begin
            gap_cnt  <= '0;
            gap_pend <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge emif_br_clk) begin
    if (emif_br_reset) begin
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= rd_issue;
      if ((wr_accept && wr_zero) || (rd_accept && rd_zero)) err_q <= 1'b1;
    end
  end

  // Outputs are forced to their reset values for every cycle reset is high.
  assign bus.emif_rd_readdatavalid = rd_valid_q & ~emif_br_reset;
  assign bus.emif_rd_rdata         = emif_br_reset ? '0 : ram_q;
  assign err_zero_burst            = err_q & ~emif_br_reset;

  emif_sdp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (EMIF_DATA_W)
  ) u_ram (
    .clk   (emif_br_clk),
    .rst   (emif_br_reset),
    .we    (ram_we),
    .waddr (wr_ram_addr),
    .wdata (bus.emif_wr_wdata),
    .re    (rd_issue),
    .raddr (rd_idx),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_emif_burst_responder.sv
// Scoreboard bench for emif_burst_responder: one responder with default timing
// and one with write stalls and read gaps, both checked against a word-array model.
module tb_emif_burst_responder;
  import emif_pkg::*;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [255:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         rst      [2];
  logic [27:0]  wr_addr  [2];
  logic         wr_write [2];
  logic [255:0] wr_wdata [2];
  logic [5:0]   wr_bc    [2];
  logic [27:0]  rd_addr  [2];
  logic         rd_read  [2];
  logic [5:0]   rd_bc    [2];
  logic         wr_wait  [2];
  logic         rd_wait  [2];
  logic         rd_valid [2];
  logic [255:0] rd_data  [2];
  logic         err      [2];

  int checks   = 0;
  int failures = 0;

  logic [255:0] model     [2][DEPTH];
  exp_t         exp_q     [2][$];
  int           acc_cnt   [2];
  logic         stall_pend[2];
  logic         exp_err   [2];

  emif_burst_responder_if bus0();
  emif_burst_responder_if bus1();

  assign bus0.emif_wr_addr       = wr_addr[0];
  assign bus0.emif_wr_write      = wr_write[0];
  assign bus0.emif_wr_wdata      = wr_wdata[0];
  assign bus0.emif_wr_burstcount = wr_bc[0];
  assign bus0.emif_rd_addr       = rd_addr[0];
  assign bus0.emif_rd_read       = rd_read[0];
  assign bus0.emif_rd_burstcount = rd_bc[0];
  assign wr_wait[0]  = bus0.emif_wr_waitrequest;
  assign rd_wait[0]  = bus0.emif_rd_waitrequest;
  assign rd_valid[0] = bus0.emif_rd_readdatavalid;
  assign rd_data[0]  = bus0.emif_rd_rdata;

  assign bus1.emif_wr_addr       = wr_addr[1];
  assign bus1.emif_wr_write      = wr_write[1];
  assign bus1.emif_wr_wdata      = wr_wdata[1];
  assign bus1.emif_wr_burstcount = wr_bc[1];
  assign bus1.emif_rd_addr       = rd_addr[1];
  assign bus1.emif_rd_read       = rd_read[1];
  assign bus1.emif_rd_burstcount = rd_bc[1];
  assign wr_wait[1]  = bus1.emif_wr_waitrequest;
  assign rd_wait[1]  = bus1.emif_rd_waitrequest;
  assign rd_valid[1] = bus1.emif_rd_readdatavalid;
  assign rd_data[1]  = bus1.emif_rd_rdata;

  emif_burst_responder #(
    .ADDR_W(10), .RD_LATENCY(4), .WR_STALL_EVERY(0), .RD_GAP_EVERY(0)
  ) dut0 (
    .emif_br_clk    (clk),
    .emif_br_reset  (rst[0]),
    .bus            (bus0),
    .err_zero_burst (err[0])
  );

  emif_burst_responder #(
    .ADDR_W(10), .RD_LATENCY(5), .WR_STALL_EVERY(3), .RD_GAP_EVERY(2)
  ) dut1 (
    .emif_br_clk    (clk),
    .emif_br_reset  (rst[1]),
    .bus            (bus1),
    .err_zero_burst (err[1])
  );

  function automatic int latOf(input int d);
    return (d == 0) ? 4 : 5;
  endfunction

  function automatic int stallOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int gapOf(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  // Cycle offset of beat k from the first beat, counting the idle cycles before it.
  function automatic int beatOffset(input int d, input int k);
    return k + ((gapOf(d) > 0) ? k / gapOf(d) : 0);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int d,
                             input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s dut%0d cycle=%0d actual=%h required=%h", name, d, cyc, act, req);
    end
  endtask

  task automatic reportTimeout(input string name, input int d);
    checks++;
    failures++;
    $display("[TB] FAIL %s dut%0d timed out at cycle=%0d", name, d, cyc);
  endtask

  task automatic checkResetState(input int d);
    checkOutput("rst_wr_waitrequest", d, wr_wait[d], 1);
    checkOutput("rst_rd_waitrequest", d, rd_wait[d], 1);
    checkOutput("rst_readdatavalid", d, rd_valid[d], 0);
    checkOutput("rst_rdata", d, rd_data[d], 0);
    checkOutput("rst_err_zero_burst", d, err[d], 0);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_valid[i]) begin
        if (exp_q[i].size() == 0) begin
          reportTimeout("stray_readdatavalid", i);
        end else begin
          exp_t e;
          e = exp_q[i].pop_front();
          checkOutput("rd_data", i, rd_data[i], e.data);
          checkOutput("rd_beat_cycle", i, 256'(cyc), 256'(e.cyc));
        end
      end
    end
  end

  task automatic applyWriteStimulus(input int d, input logic [27:0] addr, input int n);
    int   idx;
    int   k;
    int   guard;
    logic acc;
    idx   = int'(addr[14:5]);
    k     = 0;
    guard = 0;
    @(posedge clk); #1;
    wr_write[d] = 1'b1;
    wr_addr[d]  = addr;
    wr_bc[d]    = 6'(n);
    wr_wdata[d] = rand256();
    while (k < n && guard < 400) begin
      @(negedge clk);
      guard++;
      checkOutput("wr_waitrequest", d, wr_wait[d], stall_pend[d]);
      acc = !wr_wait[d];
      stall_pend[d] = 1'b0;
      if (acc) begin
        model[d][(idx + k) % DEPTH] = wr_wdata[d];
        k++;
        acc_cnt[d]++;
        if (stallOf(d) > 0 && acc_cnt[d] % stallOf(d) == 0) stall_pend[d] = 1'b1;
      end
      @(posedge clk); #1;
      if (acc) begin
        wr_wdata[d] = rand256();
        wr_addr[d]  = 28'($urandom);
        wr_bc[d]    = 6'($urandom);
      end
    end
    wr_write[d] = 1'b0;
    if (k < n) reportTimeout("wr_burst", d);
    @(negedge clk);
    checkOutput("wr_waitrequest_tail", d, wr_wait[d], stall_pend[d]);
    stall_pend[d] = 1'b0;
  endtask

  // Presents a read command, queues its expected beats and returns the accept cycle.
  task automatic issueRead(input int d, input logic [27:0] addr, input int n, output int t_acc);
    int idx;
    int guard;
    exp_t e;
    idx   = int'(addr[14:5]);
    guard = 0;
    t_acc = -1;
    @(posedge clk); #1;
    rd_read[d] = 1'b1;
    rd_addr[d] = addr;
    rd_bc[d]   = 6'(n);
    @(negedge clk);
    while (rd_wait[d] && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      reportTimeout("rd_accept", d);
    end else begin
      t_acc = cyc;
      if (n == 0) exp_err[d] = 1'b1;
      for (int k = 0; k < n; k++) begin
        e.data = model[d][(idx + k) % DEPTH];
        e.cyc  = t_acc + latOf(d) + beatOffset(d, k);
        exp_q[d].push_back(e);
      end
    end
    @(posedge clk); #1;
    rd_read[d] = 1'b0;
    rd_addr[d] = 28'($urandom);
    rd_bc[d]   = 6'($urandom);
  endtask

  task automatic applyReadStimulus(input int d, input logic [27:0] addr, input int n);
    int t_acc;
    int last;
    issueRead(d, addr, n, t_acc);
    if (t_acc >= 0) begin
      last = (n > 0) ? t_acc + latOf(d) + beatOffset(d, n - 1) : t_acc;
      for (int c = t_acc + 1; c <= last; c++) begin
        @(negedge clk);
        checkOutput("rd_waitrequest_busy", d, rd_wait[d], 1);
      end
      @(negedge clk);
      checkOutput("rd_waitrequest_idle", d, rd_wait[d], 0);
      checkOutput("err_zero_burst", d, err[d], exp_err[d]);
    end
  endtask

  initial begin
    int t_acc;
    for (int d = 0; d < 2; d++) begin
      rst[d]        = 1'b1;
      wr_addr[d]    = '0;
      wr_write[d]   = 1'b0;
      wr_wdata[d]   = '0;
      wr_bc[d]      = '0;
      rd_addr[d]    = '0;
      rd_read[d]    = 1'b0;
      rd_bc[d]      = '0;
      acc_cnt[d]    = 0;
      stall_pend[d] = 1'b0;
      exp_err[d]    = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState(0);
    checkResetState(1);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int b = 0; b < 32; b++)
        applyWriteStimulus(d, 28'(b * 1024), 32);

    applyWriteStimulus(0, 28'h0000040, 4);
    applyReadStimulus(0, 28'h0000040, 4);

    applyWriteStimulus(1, 28'h0000100, 8);
    applyReadStimulus(1, 28'h0000100, 8);
    applyReadStimulus(1, 28'h0000200, 5);

    applyWriteStimulus(0, 28'(1023 * 32), 4);
    applyReadStimulus(0, 28'(1023 * 32), 4);
    applyReadStimulus(0, 28'h8000000 | 28'(1023 * 32) | 28'h1f, 4);
    applyWriteStimulus(1, 28'(1022 * 32), 6);
    applyReadStimulus(1, 28'(1022 * 32), 6);

    issueRead(0, 28'h0000000, 32, t_acc);
    if (t_acc >= 0) begin
      while (cyc < t_acc + latOf(0) + 11) begin
        @(posedge clk); #1;
      end
      rst[0] = 1'b1;
      exp_q[0].delete();
      @(negedge clk);
      checkResetState(0);
      @(posedge clk); #1;
      @(negedge clk);
      checkResetState(0);
      @(posedge clk); #1;
      rst[0]        = 1'b0;
      acc_cnt[0]    = 0;
      stall_pend[0] = 1'b0;
      exp_err[0]    = 1'b0;
      repeat (4) begin
        @(negedge clk);
        checkOutput("post_rst_rd_waitrequest", 0, rd_wait[0], 0);
        checkOutput("post_rst_wr_waitrequest", 0, wr_wait[0], 0);
      end
    end
    applyReadStimulus(0, 28'h0000000, 8);

    applyReadStimulus(0, 28'h0000040, 0);
    applyReadStimulus(0, 28'h0000040, 2);
    applyReadStimulus(1, 28'h0000300, 0);

    for (int i = 0; i < 40; i++) begin
      int d;
      d = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0)
        applyWriteStimulus(d, 28'($urandom), int'($urandom_range(1, EMIF_MAXBURST)));
      else
        applyReadStimulus(d, 28'($urandom), int'($urandom_range(1, EMIF_MAXBURST)));
    end

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 0, 256'(exp_q[0].size()), 0);
    checkOutput("scoreboard_drained", 1, 256'(exp_q[1].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/emif_burst_responder.md
Name: emif_burst_responder

Overview:
- Avalon-MM burst responder that stands in for the external EMIF bridge behind the line buffer's EMIF write and read masters.
- Accepts 256-bit write bursts into an on-chip RAM and returns read bursts with configurable latency, gaps and back-pressure.
- Used as the memory model in line-buffer simulation benches, and as a small-frame RAM backend on boards without DDR.
- Sits on emif_br_clk directly opposite the master ports; the master and responder port names match one-to-one.

Parameters:
- ADDR_W, 10: log2 of RAM depth in 256-bit words (default 1024 words).
- RD_LATENCY, 4: cycles from read-command acceptance to first readdatavalid; legal range 2..15.
- WR_STALL_EVERY, 0: after every N accepted write beats, insert 1 waitrequest cycle; 0 disables.
- RD_GAP_EVERY, 0: after every N returned read beats, insert 1 idle cycle; 0 disables.

Ports:
- emif_br_clk  in  1  sole clock.
- emif_br_reset  in  1  reset.
- emif_wr_addr  in  28  byte address; bits [4:0] are ignored.
- emif_wr_write  in  1  write request.
- emif_wr_wdata  in  256  write beat data.
- emif_wr_burstcount  in  6  beats in the burst, 1..32; sampled on the first beat only.
- emif_wr_waitrequest  out  1  write back-pressure.
- emif_rd_addr  in  28  byte address; bits [4:0] are ignored.
- emif_rd_read  in  1  read command.
- emif_rd_burstcount  in  6  beats requested, 1..32.
- emif_rd_waitrequest  out  1  read command back-pressure.
- emif_rd_rdata  out  256  read beat data.
- emif_rd_readdatavalid  out  1  read beat valid.
- err_zero_burst  out  1  sticky flag: a zero burstcount was seen.

Behaviour:
- Clock and reset: one clock, emif_br_clk. Reset emif_br_reset is synchronous and active-high.
- Reset values:
  - While reset is high, both waitrequests = 1; readdatavalid = 0, rdata = 0, err_zero_burst = 0.
  - All FSMs go to IDLE and all counters clear.
  - RAM contents are not cleared.
  - Reset asserted mid-burst abandons the burst immediately; no further readdatavalid is produced.
- Word index = addr[ADDR_W+4:5]. Upper address bits are ignored, so addresses alias modulo 2^ADDR_W words. Beat addresses increment by 1 word and wrap modulo depth.
- Write FSM, states IDLE and BURST:
  - A beat is accepted when write & !wr_waitrequest.
  - In IDLE, an accepted beat latches word index and burstcount, and writes wdata at that index in the same cycle. If burstcount == 1, stay in IDLE. Otherwise go to BURST with remaining = burstcount-1 and next index = index+1.
  - In BURST, each accepted beat writes at the next index and decrements remaining; at 0, return to IDLE.
  - addr and burstcount are ignored on non-first beats.
- Write stall: when WR_STALL_EVERY = N > 0, a beat counter counts accepted beats across bursts. In the cycle after the Nth acceptance, wr_waitrequest = 1 for exactly 1 cycle and the counter clears. Otherwise wr_waitrequest = 0.
- Read FSM, states IDLE, WAIT and STREAM:
  - In IDLE, rd_waitrequest = 0. read & !waitrequest at cycle T latches index and count, then enters WAIT.
  - rd_waitrequest = 1 in all states other than IDLE. Only one burst is outstanding at a time.
  - WAIT lasts until beat 0 is presented with readdatavalid = 1 at cycle T+RD_LATENCY. The RAM read is registered, so the address is issued at T+RD_LATENCY-1.
  - STREAM delivers 1 beat per cycle, except that after every RD_GAP_EVERY beats, 1 cycle has readdatavalid = 0. Gap cycles do not advance the beat count.
  - The cycle after the last beat, the FSM is in IDLE and rd_waitrequest = 0.
  - rdata holds its value when readdatavalid = 0.
- Zero burstcount: the command is accepted, err_zero_burst is set (sticky), and no data is written or returned. The FSM stays in IDLE.
- burstcount > 32 is served as given; no clipping.
- Read/write to the same word:
  - Read-during-write is old-data: a beat whose RAM read cycle coincides with a write to that word returns the pre-write content.
  - A write in any earlier cycle is visible.
- The write and read paths are fully concurrent, with no arbitration between them.

Decomposition:
- Package emif_pkg holds:
  - EMIF_ADDR_W = 28, EMIF_DATA_W = 256, EMIF_BURST_W = 6;
  - EMIF_WORD_OFS = 5, EMIF_MAXBURST = 32;
  - the read FSM state enum and the write FSM state enum.
- Sub-module: emif_sdp_ram, a 256-bit simple dual-port RAM with 2^ADDR_W words, a registered read port and old-data read-during-write. It is inferred, not an IP instance.
- The FSMs, stall/gap counters and latency delay line stay in the top module.

Test Plan:
- Write burst of 4 at addr 0x0000040 (word 2), data D0..D3 with defaults, then read burst of 4 at the same addr accepted at cycle T -> readdatavalid at T+4..T+7 with D0..D3; rd_waitrequest = 1 during T+1..T+7 and 0 at T+8.
- WR_STALL_EVERY = 3, write burst of 8 -> wr_waitrequest high exactly 1 cycle after beats 3 and 6; the master holds data; all 8 words read back correctly.
- RD_GAP_EVERY = 2, read burst of 5 -> valid pattern 1,1,0,1,1,0,1 starting at T+RD_LATENCY.
- Write burst of 4 at the last word (index 1023) -> data lands in words 1023, 0, 1, 2; a read of 4 from word 1023 returns the same data.
- Read of 32 beats, with emif_br_reset asserted 1 cycle after beat 10 -> readdatavalid = 0 from the next cycle; both waitrequests = 1 during reset; a new read after reset returns correct data.
- Read burstcount = 0 -> err_zero_burst = 1 and stays set; no readdatavalid; rd_waitrequest returns to 0 the next cycle.
